// File: rtl/opll_write_queue.sv
// opll_write_queue: buffers CPU register writes and replays them on the opll
// bus pins with YM2413 recovery spacing, paced by the shared xena enable.
module opll_write_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_WAIT = 12,
    parameter int unsigned DATA_WAIT = 84
) (
    input  logic                     xin,
    input  logic                     ic_n,
    input  logic                     xena,
    input  logic                     cpu_wr,
    input  logic                     cpu_a,
    input  logic [7:0]               cpu_d,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [7:0]               d,
    output logic                     a,
    output logic                     cs_n,
    output logic                     we_n
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned MAXW = (DATA_WAIT > ADDR_WAIT) ? DATA_WAIT : ADDR_WAIT;
    localparam int unsigned CW   = $clog2(MAXW) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_full;
    logic          r_overflow;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_d;
    logic          r_a;
    logic          r_cs_n;
    logic          r_we_n;

    logic          w_pop;
    logic          w_push;
    logic [8:0]    w_head;
    logic [LW-1:0] w_level_nxt;

    // Pop/push qualification; a pop frees the slot a full-FIFO push lands in.
    always_comb begin
        w_pop       = (r_state == ST_IDLE) && xena && (r_level != '0);
        w_push      = cpu_wr && ((r_level != LW'(DEPTH)) || w_pop);
        w_head      = r_mem[r_rd_ptr];
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // FIFO storage; contents are invalidated by pointer reset, not cleared.
    always_ff @(posedge xin) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cpu_a, cpu_d};
        end
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge xin or negedge ic_n) begin
        if (!ic_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == LW'(DEPTH));
            r_overflow <= cpu_wr && !w_push;
        end
    end

    // Bus sequencer: one strobe per entry, then recovery; frozen while xena=0.
    // Leaving WAIT as the counter reaches 1 gives strobe-to-strobe spacing of
    // WAIT+1 xena ticks (13 after an address, 85 after data).
    always_ff @(posedge xin or negedge ic_n) begin
        if (!ic_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_d     <= '0;
            r_a     <= 1'b0;
            r_cs_n  <= 1'b1;
            r_we_n  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_a     <= w_head[8];
                        r_d     <= w_head[7:0];
                        r_cs_n  <= 1'b0;
                        r_we_n  <= 1'b0;
                        r_state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (xena) begin
                        r_cs_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_cnt   <= r_a ? CW'(DATA_WAIT - 1) : CW'(ADDR_WAIT - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (xena) begin
                        if (r_cnt <= CW'(1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                end
            endcase
        end
    end

    assign level    = r_level;
    assign full     = r_full;
    assign overflow = r_overflow;
    assign d        = r_d;
    assign a        = r_a;
    assign cs_n     = r_cs_n;
    assign we_n     = r_we_n;

endmodule
